// File: rtl/wb_mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: state encoding,
// grant indices and the default watchdog period.
package wb_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_t;

    localparam logic GRANT_IDX_M0 = 1'b0;
    localparam logic GRANT_IDX_M1 = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for wb_mem_arbiter: revokes a grant whose strobe goes unacked
// for TIMEOUT_CYCLES and keeps that master out until it drops cyc.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_WIDTH  = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] grant,
    input  logic       m0_cyc,
    input  logic       m0_stb,
    input  logic       m1_cyc,
    input  logic       m1_stb,
    input  logic       s_ack,
    output logic       revoke,
    output logic       timeout,
    output logic [1:0] blocked
);

    logic [TIMEOUT_WIDTH-1:0] stall_cnt;
    logic                     stall;

    assign stall  = ((grant[0] & m0_stb) | (grant[1] & m1_stb)) & ~s_ack;
    // Revoke on the edge where the stall count would reach TIMEOUT_CYCLES.
    assign revoke = stall && (stall_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
            blocked   <= 2'b00;
        end else begin
            timeout <= revoke;

            if ((grant == 2'b00) || s_ack || revoke) begin
                stall_cnt <= '0;
            end else if (stall) begin
                stall_cnt <= stall_cnt + TIMEOUT_WIDTH'(1);
            end

            if (revoke && grant[0]) begin
                blocked[0] <= 1'b1;
            end else if (!m0_cyc) begin
                blocked[0] <= 1'b0;
            end

            if (revoke && grant[1]) begin
                blocked[1] <= 1'b1;
            end else if (!m1_cyc) begin
                blocked[1] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of the memory controller (camera writer, host reader).
// Define WB_ARB_TIMEOUT_EN to add the hung-grant watchdog (wb_arb_watchdog).
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_i_we,
    input  logic        m0_i_stb,
    input  logic        m0_i_cyc,
    input  logic [3:0]  m0_i_sel,
    input  logic [31:0] m0_i_adr,
    input  logic [31:0] m0_i_dat,
    output logic [31:0] m0_o_dat,
    output logic        m0_o_ack,
    output logic        m0_o_int,
    input  logic        m1_i_we,
    input  logic        m1_i_stb,
    input  logic        m1_i_cyc,
    input  logic [3:0]  m1_i_sel,
    input  logic [31:0] m1_i_adr,
    input  logic [31:0] m1_i_dat,
    output logic [31:0] m1_o_dat,
    output logic        m1_o_ack,
    output logic        m1_o_int,
    output logic        s_o_we,
    output logic        s_o_stb,
    output logic        s_o_cyc,
    output logic [3:0]  s_o_sel,
    output logic [31:0] s_o_adr,
    output logic [31:0] s_o_dat,
    input  logic [31:0] s_i_dat,
    input  logic        s_i_ack,
    input  logic        s_i_int,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    arb_state_t state;
    arb_state_t next_state;
    logic       r_last;
    logic       revoke;
    logic [1:0] blocked;
    logic       req0;
    logic       req1;

    if ((TIMEOUT_WIDTH < 1) || (TIMEOUT_WIDTH > 30) || ((1 << TIMEOUT_WIDTH) <= TIMEOUT_CYCLES)) begin : g_cfg_check
        $error("wb_mem_arbiter: TIMEOUT_WIDTH too narrow for TIMEOUT_CYCLES");
    end

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .grant  (o_grant),
        .m0_cyc (m0_i_cyc),
        .m0_stb (m0_i_stb),
        .m1_cyc (m1_i_cyc),
        .m1_stb (m1_i_stb),
        .s_ack  (s_i_ack),
        .revoke (revoke),
        .timeout(o_timeout),
        .blocked(blocked)
    );
`else
    assign revoke    = 1'b0;
    assign blocked   = 2'b00;
    assign o_timeout = 1'b0;
`endif

    assign req0 = m0_i_cyc & ~blocked[0];
    assign req1 = m1_i_cyc & ~blocked[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            r_last <= GRANT_IDX_M1;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == GRANT0) begin
                r_last <= GRANT_IDX_M0;
            end else if (state == IDLE && next_state == GRANT1) begin
                r_last <= GRANT_IDX_M1;
            end
        end
    end

    // Grants always return through IDLE, so there is one dead cycle between owners.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = (r_last == GRANT_IDX_M1) ? GRANT0 : GRANT1;
                end else if (req0) begin
                    next_state = GRANT0;
                end else if (req1) begin
                    next_state = GRANT1;
                end
            end
            GRANT0: if (!m0_i_cyc || revoke) next_state = IDLE;
            GRANT1: if (!m1_i_cyc || revoke) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        s_o_we   = 1'b0;
        s_o_stb  = 1'b0;
        s_o_cyc  = 1'b0;
        s_o_sel  = 4'h0;
        s_o_adr  = 32'h0;
        s_o_dat  = 32'h0;
        m0_o_ack = 1'b0;
        m1_o_ack = 1'b0;
        case (state)
            GRANT0: begin
                s_o_we   = m0_i_we;
                s_o_stb  = m0_i_stb;
                s_o_cyc  = m0_i_cyc;
                s_o_sel  = m0_i_sel;
                s_o_adr  = m0_i_adr;
                s_o_dat  = m0_i_dat;
                m0_o_ack = s_i_ack;
            end
            GRANT1: begin
                s_o_we   = m1_i_we;
                s_o_stb  = m1_i_stb;
                s_o_cyc  = m1_i_cyc;
                s_o_sel  = m1_i_sel;
                s_o_adr  = m1_i_adr;
                s_o_dat  = m1_i_dat;
                m1_o_ack = s_i_ack;
            end
            default: ;
        endcase
    end

    assign o_grant  = state;
    assign m0_o_dat = s_i_dat;
    assign m1_o_dat = s_i_dat;
    assign m0_o_int = s_i_int;
    assign m1_o_int = s_i_int;

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Two-master Wishbone arbiter sharing the single memory slave port between the camera's ping-pong-FIFO-to-memory writer (master 0) and a host/DMA reader (master 1). Grants are registered, round-robin on ties, and held for the full duration of the granted master's `cyc`. It sits between the camera slave's `mem_o_*`/`mem_i_*` port and the memory controller, with an optional watchdog that reclaims a hung grant.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: stalled-strobe cycles before a grant is revoked (only with `WB_ARB_TIMEOUT_EN`).
- `TIMEOUT_WIDTH`, default 11: counter width; must satisfy 2^`TIMEOUT_WIDTH` > `TIMEOUT_CYCLES`.

Ports (`mN_` = one set per master, N = 0, 1):
- `clk`  input  1  clock
- `rst`  input  1  reset; synchronous, active-high; clock `clk`
- `mN_i_we`  input  1  master write enable
- `mN_i_stb`  input  1  master strobe
- `mN_i_cyc`  input  1  master cycle; the bus request
- `mN_i_sel`  input  4  master byte select
- `mN_i_adr`  input  32  master address
- `mN_i_dat`  input  32  master write data
- `mN_o_dat`  output  32  read data; broadcast copy of `s_i_dat`
- `mN_o_ack`  output  1  ack, routed to the granted master only
- `mN_o_int`  output  1  broadcast copy of `s_i_int`
- `s_o_we`, `s_o_stb`, `s_o_cyc`  output  1 each  to memory slave
- `s_o_sel`  output  4  to memory slave
- `s_o_adr`, `s_o_dat`  output  32 each  to memory slave
- `s_i_dat`  input  32  slave read data
- `s_i_ack`  input  1  slave ack
- `s_i_int`  input  1  slave interrupt
- `o_grant`  output  2  one-hot current grant; 00 = idle
- `o_timeout`  output  1  one-cycle pulse on watchdog revoke

## Operation
- States: IDLE, GRANT0, GRANT1. One-hot `o_grant` is decoded from the state.
- IDLE:
  - Only `m0_i_cyc` high → GRANT0. Only `m1_i_cyc` high → GRANT1.
  - Both high → grant the master that was not granted last. `r_last` resets to 1, so master 0 wins the first tie.
- GRANTn:
  - Slave outputs are combinationally muxed from master n, and `s_i_ack` goes to `mN_o_ack`.
  - The other master's ack is held 0.
  - `r_last` <= n when the state is entered.
  - Exit to IDLE when `mN_i_cyc` deasserts. There is no direct GRANT0↔GRANT1 hop, so one IDLE cycle always separates grants.
- In IDLE, all `s_o_*` are 0 and both acks are 0.
- A requester that is not granted waits with its `cyc`/`stb` held. The arbiter never acks it.
- `mN_o_dat` and `mN_o_int` are pass-through to both masters regardless of grant.

## Timing
- Reset values: state IDLE, `r_last` = 1, `o_grant` = 00, `o_timeout` = 0. All `s_o_*` are 0 and all `mN_o_ack` are 0.
- `mN_o_dat` and `mN_o_int` follow the slave combinationally, including during reset.
- Grant latency: `cyc` rises in cycle k while IDLE → state updates at edge k+1 → `s_o_cyc` is visible in cycle k+1.
- Release: `cyc` falls in cycle j → IDLE from edge j+1. The earliest next grant is visible at j+2.
- Ack path is combinational slave→master (zero added latency). `stb` and the address path are combinational master→slave once granted.
- Simultaneous request with release: if master 0 drops `cyc` at the same edge master 1 raises it, the sequence is IDLE for one cycle, then GRANT1.
- Reset mid-transfer: the grant drops at the next edge and the slave sees `cyc` = 0. An ack in flight is discarded.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- Defined:
  - A counter increments each GRANTn cycle with `mN_i_stb` = 1 and `s_i_ack` = 0, and clears on ack or on leaving GRANTn.
  - When the counter reaches `TIMEOUT_CYCLES`, the state goes to IDLE, `o_timeout` pulses for one cycle, and master n is marked blocked.
  - A blocked master is ignored in IDLE until its `cyc` deasserts for at least one cycle.
- Undefined: no counter and no blocking logic; `o_timeout` is tied 0.

## Structure
- Shared package holds:
  - state encoding (IDLE = 2'b00, GRANT0 = 2'b01, GRANT1 = 2'b10);
  - grant index constants;
  - the default `TIMEOUT_CYCLES`.
- Sub-module `wb_arb_watchdog`: stall counter plus blocked flags, instantiated only under `WB_ARB_TIMEOUT_EN`.

## Test plan
- Reset released, no requests → `o_grant` = 00, `s_o_cyc` = 0, both acks 0.
- `m0_i_cyc` and `m1_i_cyc` rise together at cycle 5 → `o_grant` = 01 at cycle 6.
  - m0 releases at 20 → IDLE at 21, `o_grant` = 10 at 22.
- m1 performs a write to `adr` 0x100 with `dat` 0xDEADBEEF while m0 is idle → slave sees exactly that; `m1_o_ack` echoes `s_i_ack`; `m0_o_ack` stays 0.
- m0 holds `cyc` across 4 back-to-back acked reads while m1 requests → m1 is not granted until two cycles after m0 drops `cyc`.
- `rst` asserted in GRANT1 mid-strobe → next cycle `s_o_cyc` = 0, `o_grant` = 00, `r_last` = 1.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, m0 strobes and the slave never acks:
  - `o_timeout` pulses after 8 stalled cycles, and m1 (requesting) is granted two cycles later.
  - m0 is not re-granted until it drops `cyc` for at least one cycle.
